// File: rtl/lm96570_spi_master_if.sv
// Command/readback bus between the control PIO bank and the LM96570 serial engine.
//   start  : one-cycle command strobe
//   rw     : 1 = read, 0 = write (captured with start)
//   addr   : register address (captured with start)
//   wdata  : write data (captured with start, ignored for reads)
//   rdata  : last read result, held until the next read completes
//   status : {sle, sdo_sync, start_ignored, last_rw, done, busy}
// The engine connects through the slave modport; the command source uses master.
interface lm96570_spi_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 48
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [5:0]        status;

    modport master (output start, rw, addr, wdata, input rdata, status);
    modport slave  (input start, rw, addr, wdata, output rdata, status);
endinterface

// File: rtl/lm96570_spi_master.sv
// Serial engine that writes and reads LM96570 beamformer registers over the
// sclk/sle/sdi/sdo interface. One frame is {rw, addr, data}, shifted MSB first.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : command/readback bus (start, rw, addr, wdata, rdata, status)
//   sclk         : serial clock, idles low, CLK_DIV clk cycles per half-period
//   sle          : frame/latch enable, high for the whole frame
//   sdi          : serial data to the device, changes only while sclk is low
//   sdo          : serial data from the device, asynchronous to clk
module lm96570_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 48
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lm96570_spi_master_if.slave  bus,
    output logic                 sclk,
    output logic                 sle,
    output logic                 sdi,
    input  logic                 sdo
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rw_q, rw_d;
    logic               sclk_q, sclk_d;
    logic               sle_q, sle_d;
    logic               sdi_q, sdi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_ignored_q, start_ignored_d;
    logic               last_rw_q, last_rw_d;
    logic               sdo_meta_q, sdo_meta_d;
    logic               sdo_sync_q, sdo_sync_d;
    logic               last_div;

    // Every non-idle state lasts exactly CLK_DIV cycles.
    assign last_div = (div_q == 8'(CLK_DIV - 1));

    always_comb begin
        state_d         = state_q;
        div_d           = '0;
        bit_d           = bit_q;
        sh_d            = sh_q;
        rx_d            = rx_q;
        rdata_d         = rdata_q;
        rw_d            = rw_q;
        sclk_d          = sclk_q;
        sle_d           = sle_q;
        sdi_d           = sdi_q;
        busy_d          = busy_q;
        done_d          = done_q;
        start_ignored_d = start_ignored_q;
        last_rw_d       = last_rw_q;
        sdo_meta_d      = sdo;
        sdo_sync_d      = sdo_meta_q;

        if (state_q != IDLE && !last_div) div_d = div_q + 8'd1;

        // Any start outside IDLE is dropped, including the cycle busy falls.
        if (bus.start && state_q != IDLE) start_ignored_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d         = SETUP;
                    sh_d            = {bus.rw, bus.addr, bus.rw ? {DATA_W{1'b0}} : bus.wdata};
                    rw_d            = bus.rw;
                    rx_d            = '0;
                    bit_d           = '0;
                    busy_d          = 1'b1;
                    done_d          = 1'b0;
                    start_ignored_d = 1'b0;
                    sle_d           = 1'b1;
                    sclk_d          = 1'b0;
                    sdi_d           = bus.rw;
                end
            end
            SETUP: begin
                if (last_div) state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (last_div) begin
                    state_d = SHIFT_HI;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (last_div) begin
                    sclk_d = 1'b0;
                    // Sample the device late in the high phase; only data-field bits are kept.
                    if (rw_q && bit_q >= BIT_W'(1 + ADDR_W)) rx_d = {rx_q[DATA_W-2:0], sdo_sync_q};
                    sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
                    sdi_d = sh_q[FRAME_W-2];
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = LATCH;
                        bit_d   = '0;
                    end else begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            LATCH: begin
                if (last_div) begin
                    state_d   = IDLE;
                    sle_d     = 1'b0;
                    sdi_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    last_rw_d = rw_q;
                    if (rw_q) rdata_d = rx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            div_q           <= '0;
            bit_q           <= '0;
            sh_q            <= '0;
            rx_q            <= '0;
            rdata_q         <= '0;
            rw_q            <= 1'b0;
            sclk_q          <= 1'b0;
            sle_q           <= 1'b0;
            sdi_q           <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            start_ignored_q <= 1'b0;
            last_rw_q       <= 1'b0;
            sdo_meta_q      <= 1'b0;
            sdo_sync_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            div_q           <= div_d;
            bit_q           <= bit_d;
            sh_q            <= sh_d;
            rx_q            <= rx_d;
            rdata_q         <= rdata_d;
            rw_q            <= rw_d;
            sclk_q          <= sclk_d;
            sle_q           <= sle_d;
            sdi_q           <= sdi_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            start_ignored_q <= start_ignored_d;
            last_rw_q       <= last_rw_d;
            sdo_meta_q      <= sdo_meta_d;
            sdo_sync_q      <= sdo_sync_d;
        end
    end

    assign sclk       = sclk_q;
    assign sle        = sle_q;
    assign sdi        = sdi_q;
    assign bus.rdata  = rdata_q;
    assign bus.status = {sle_q, sdo_sync_q, start_ignored_q, last_rw_q, done_q, busy_q};
endmodule

// File: tb/tb_lm96570_spi_master.sv
// Directed bench for lm96570_spi_master: default build (CLK_DIV=4, DATA_W=48)
// plus a CLK_DIV=3, DATA_W=8 build. Expected sdi bits and rdata are queued when a
// command is issued and consumed when the DUT shifts/finishes the frame.
module tb_lm96570_spi_master;
    localparam int AW   = 5;
    localparam int DW   = 48;
    localparam int FW   = 1 + AW + DW;
    localparam int DIV  = 4;
    localparam int BUSY = DIV * (2 * FW + 2);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default build
    lm96570_spi_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic sclk, sle, sdi, sdo;
    lm96570_spi_master #(.CLK_DIV(DIV), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .sclk(sclk), .sle(sle), .sdi(sdi), .sdo(sdo)
    );

    // Small build
    lm96570_spi_master_if #(.ADDR_W(AW), .DATA_W(8)) bus_s ();
    logic sclk_s, sle_s, sdi_s, sdo_s;
    lm96570_spi_master #(.CLK_DIV(3), .ADDR_W(AW), .DATA_W(8)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus_s), .sclk(sclk_s), .sle(sle_s), .sdi(sdi_s), .sdo(sdo_s)
    );

    // Device models: count sclk falling edges within a frame; fcnt is the index
    // of the bit now being transferred, and sdo carries data bits MSB first.
    logic [DW-1:0] dev_data = '0;
    int            fcnt = 0;
    logic          sclk_d1 = 1'b0, sle_d1 = 1'b0;
    always @(posedge clk) begin
        sclk_d1 <= sclk;
        sle_d1  <= sle;
        if (sle && !sle_d1) fcnt <= 0;
        else if (sclk_d1 && !sclk) fcnt <= fcnt + 1;
    end
    assign sdo = (fcnt >= 1 + AW && fcnt < FW) ? dev_data[FW - 1 - fcnt] : 1'b0;

    logic [7:0] dev_s = '0;
    int         fcnt_s = 0;
    logic       sclk_s_d1 = 1'b0, sle_s_d1 = 1'b0;
    always @(posedge clk) begin
        sclk_s_d1 <= sclk_s;
        sle_s_d1  <= sle_s;
        if (sle_s && !sle_s_d1) fcnt_s <= 0;
        else if (sclk_s_d1 && !sclk_s) fcnt_s <= fcnt_s + 1;
    end
    assign sdo_s = (fcnt_s >= 1 + AW && fcnt_s < 1 + AW + 8) ? dev_s[1 + AW + 8 - 1 - fcnt_s] : 1'b0;

    // Scoreboard
    bit            exp_sdi_q[$];
    logic [DW-1:0] exp_rdata_q[$];
    logic [DW-1:0] cur_rdata = '0;
    int            pulses = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each sclk rise must present the next queued frame bit on sdi.
    always @(posedge sclk) begin
        #1;
        pulses++;
        if (exp_sdi_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sdi_extra_pulse: observed=pulse %0d expected=no pulse", pulses);
        end else begin
            chk("sdi_bit", sdi, exp_sdi_q.pop_front());
        end
    end

    task automatic do_start(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] w);
        logic [FW-1:0] fr;
        fr = {r, a, r ? {DW{1'b0}} : w};
        @(negedge clk);
        bus.start = 1'b1;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = w;
        exp_sdi_q.delete();
        for (int i = FW - 1; i >= 0; i--) exp_sdi_q.push_back(fr[i]);
        exp_rdata_q.push_back(r ? dev_data : cur_rdata);
        pulses = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_rise", bus.status[0], 1);
        chk("sle_rise", sle, 1);
    endtask

    // Called 'elapsed' edges after the accepting edge; checks busy drops exactly BUSY edges after it.
    task automatic finish_frame(input int elapsed, input logic r, input bit late_start, input string tag);
        logic [DW-1:0] e;
        repeat (BUSY - 1 - elapsed) @(posedge clk);
        #1;
        chk({tag, "_busy_hold"}, bus.status[0], 1);
        if (late_start) begin
            @(negedge clk);
            bus.start = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "_busy_fall"}, bus.status[0], 0);
        chk({tag, "_done"}, bus.status[1], 1);
        chk({tag, "_last_rw"}, bus.status[2], r);
        chk({tag, "_sle_low"}, {sle, bus.status[5]}, 2'b00);
        chk({tag, "_pulses"}, pulses, FW);
        chk({tag, "_bits_left"}, exp_sdi_q.size(), 0);
        if (late_start) chk({tag, "_late_start_ignored"}, bus.status[3], 1);
        if (exp_rdata_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_rdata: observed=no queued entry expected=one", tag);
        end else begin
            e = exp_rdata_q.pop_front();
            chk({tag, "_rdata"}, bus.rdata, e);
            cur_rdata = e;
        end
    endtask

    initial begin
        int rise1, rise2, fall_at;
        logic prev;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus_s.start = 1'b0; bus_s.rw = 1'b0; bus_s.addr = '0; bus_s.wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pins", {sclk, sle, sdi}, 3'b000);
        chk("rst_status", bus.status, 6'd0);
        chk("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write frame
        do_start(1'b0, 5'h0A, 48'h1234_5678_9ABC);
        finish_frame(0, 1'b0, 1'b0, "wr");

        // Reset mid-frame, with sclk high at the moment of reset
        do_start(1'b0, 5'h11, 48'hFEDC_BA98_7654);
        repeat (201) @(posedge clk);
        #1;
        chk("pre_reset_sclk", sclk, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_pins", {sclk, sle, sdi}, 3'b000);
        chk("midrst_status", bus.status, 6'd0);
        chk("midrst_rdata", bus.rdata, 0);
        exp_sdi_q.delete();
        exp_rdata_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        do_start(1'b0, 5'h15, 48'h0F0F_0000_FFFF);
        finish_frame(0, 1'b0, 1'b0, "post_rst");

        // Read frame with an ignored start while busy
        dev_data = 48'hA5A5_0F0F_C3C3;
        do_start(1'b1, 5'h03, 48'hFFFF_FFFF_FFFF);
        repeat (98) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 5'h1F; bus.wdata = '1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_start_ignored", bus.status[3], 1);
        chk("busy_start_still_busy", bus.status[0], 1);
        finish_frame(99, 1'b1, 1'b0, "rd");
        chk("rd_status", bus.status & 6'b101111, 6'b001110);

        // Back-to-back: start in the first IDLE cycle; sle low for one cycle only
        dev_data = 48'h8000_0000_0001;
        do_start(1'b1, 5'h1C, 48'h0);
        chk("b2b_ignored_cleared", bus.status[3], 0);
        chk("b2b_done_cleared", bus.status[1], 0);
        // Start landing on the edge where busy falls must be dropped
        finish_frame(0, 1'b1, 1'b1, "b2b");
        chk("b2b_status", bus.status & 6'b101111, 6'b001110);
        do_start(1'b0, 5'h01, 48'hC000_0000_0003);
        chk("after_late_ignored_cleared", bus.status[3], 0);
        finish_frame(0, 1'b0, 1'b0, "last_wr");
        chk("last_wr_rdata_held", bus.rdata, 48'h8000_0000_0001);

        // Small build: CLK_DIV=3, DATA_W=8 read
        dev_s = 8'h81;
        @(negedge clk);
        bus_s.start = 1'b1; bus_s.rw = 1'b1; bus_s.addr = 5'h07; bus_s.wdata = 8'h00;
        @(posedge clk);
        #1;
        bus_s.start = 1'b0;
        rise1 = -1; rise2 = -1; fall_at = -1; prev = sclk_s;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk);
            #1;
            if (sclk_s && !prev) begin
                if (rise1 < 0) rise1 = i;
                else if (rise2 < 0) rise2 = i;
            end
            if (!bus_s.status[0] && fall_at < 0) fall_at = i;
            prev = sclk_s;
        end
        chk("s_sclk_period", rise2 - rise1, 6);
        chk("s_busy_time", fall_at, 90);
        chk("s_rdata", bus_s.rdata, 8'h81);
        chk("s_status", bus_s.status & 6'b101111, 6'b000110);
        chk("s_idle_pins", {sclk_s, sle_s, sdi_s}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lm96570_spi_master.md
Name: lm96570_spi_master

Overview:
- Serial engine that programs and reads back LM96570 beamformer registers over the 3-wire-plus-latch interface (sclk, sle, sdi, sdo).
- Sits directly upstream of the 6-bit status PIO. Its status[5:0] output drives that PIO's in_port; rdata is captured by separate readback PIOs.
- Driven by a start/command strobe from the control PIO bank.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 3..255.
- ADDR_W, 5, register address width.
- DATA_W, 48, data field width per frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk.
- start  in  1  one-cycle command strobe.
- rw  in  1  1 = read, 0 = write; captured with start.
- addr  in  ADDR_W  register address; captured with start.
- wdata  in  DATA_W  write data; captured with start; ignored for reads.
- sclk  out  1  serial clock to LM96570; idles low.
- sle  out  1  frame/latch enable; high for the whole frame.
- sdi  out  1  serial data to device, MSB first.
- sdo  in  1  serial data from device; asynchronous to clk.
- rdata  out  DATA_W  last read result; held until the next read completes.
- status  out  6  {sle, sdo_sync, start_ignored, last_rw, done, busy}; feeds the status PIO.

Behaviour:
- Reset values: sclk=0, sle=0, sdi=0, rdata=0, status=0, FSM=IDLE, all counters 0. Reset asserted mid-frame aborts immediately to these values; no partial rdata update.
- sdo passes through a 2-flop synchroniser (sdo_sync) before any use.
- Frame layout: FRAME_W = 1+ADDR_W+DATA_W (54 by default). Shift register loaded {rw, addr, wdata}, MSB first. For reads the data field of sdi is driven 0.
- FSM states:
  - IDLE: start=1 loads the shift register, sets busy=1 and clears done on the next edge, then goes to SETUP.
  - SETUP: lasts CLK_DIV cycles, sle=1, sclk=0, sdi=frame MSB.
  - SHIFT_LO: lasts CLK_DIV cycles, sclk=0.
  - SHIFT_HI: lasts CLK_DIV cycles, sclk=1. On the last cycle of SHIFT_HI, if rw=1 and the bit index lies in the data field, sdo_sync is shifted into the rx register (MSB first). On exit, the bit counter increments and sdi advances to the next bit. After bit FRAME_W-1, go to LATCH; otherwise go to SHIFT_LO.
  - LATCH: lasts CLK_DIV cycles, sclk=0, sle=1. On exit, sle=0, busy=0, done=1 (sticky), last_rw=rw. If rw=1, rdata is loaded from the rx register in the same edge. Return to IDLE.
- Timing: total busy time = CLK_DIV*(2*FRAME_W+2) cycles; 440 cycles at the defaults.
- Start handling:
  - start while busy is ignored and sets start_ignored (sticky); it clears on the next accepted start.
  - start in the same cycle that busy falls is ignored (FSM not yet in IDLE).
  - Back-to-back frames: at least one IDLE cycle between frames, during which sle=0.
- done: cleared only by an accepted start or by reset.
- status is registered and updates in the same edge as the internal state. status[5] mirrors sle; status[4] mirrors sdo_sync continuously, including in IDLE.
- sdi changes only while sclk=0, never on the sclk rising edge.

Test Plan:
- Write: reset, start with rw=0, addr=5'h0A, wdata=48'h123456789ABC at edge k -> busy=1 at k+1. sdi sampled on sclk rising edges equals 0,01010,then wdata bits MSB-first. Exactly 54 sclk pulses. busy=0, done=1, rdata=0 at k+441.
- Read: rw=1, addr=5'h03; model drives sdo with 48'hA5A5_0F0F_C3C3 MSB-first, updating on sclk falling edges -> rdata=48'hA5A5_0F0F_C3C3 at k+441, status=6'b0x0110 (sle=0, sdo_sync=x, start_ignored=0, last_rw=1, done=1, busy=0).
- Busy start: second start at k+100 -> frame unaffected, start_ignored=1. Next accepted start clears start_ignored and done at the following edge.
- Reset mid-frame: reset_n low at k+200 -> sclk/sle/sdi/status=0 asynchronously, rdata keeps its prior value 0. A new frame after release completes normally.
- Back-to-back: start in the first IDLE cycle after done -> sle low for exactly 1 cycle between frames, and the second frame is bit-exact.
- CLK_DIV=3, DATA_W=8 build: read 8'h81 -> sclk period 6 cycles, busy time 3*(2*14+2)=90 cycles, rdata=8'h81.
